// File: rtl/sram_arb_pkg.sv
// Shared widths and payload types for the SRAM port arbiter.
package sram_arb_pkg;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned BE_W   = DATA_W / 8;

   typedef logic [0:0] port_id_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic              rd;
      logic              wr;
      logic [DATA_W-1:0] wdata;
   } sram_cmd_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// One Avalon-MM requester port: master drives the request, slave answers with waitrequest and read returns.
interface sram_port_arbiter_if;
   import sram_arb_pkg::*;

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (output address, byteenable, read, write, writedata,
                   input  waitrequest, readdata, readdatavalid);
   modport slave  (input  address, byteenable, read, write, writedata,
                   output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/sram_arb_tag_fifo.sv
// In-order FIFO of 1-bit port tags, one entry per outstanding read; simultaneous push and pop allowed when full.
module sram_arb_tag_fifo
   import sram_arb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  port_id_t         push_tag,
   output port_id_t         head_tag,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   port_id_t         mem_q [DEPTH];
   port_id_t         mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_tag;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_tag = mem_q[rd_ptr_q];
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller Avalon-MM port between fetch (m0) and load/store (m1), steering read returns in order.
// Define SRAM_ARB_RR_EN for round-robin selection; otherwise port 1 has fixed priority over port 0.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   sram_port_arbiter_if.slave  m0,
   sram_port_arbiter_if.slave  m1,
   output logic [ADDR_W-1:0]   controller_address,
   output logic [BE_W-1:0]     controller_byteenable,
   output logic                controller_read,
   output logic                controller_write,
   output logic [DATA_W-1:0]   controller_writedata,
   input  logic [DATA_W-1:0]   controller_readdata,
   input  logic                controller_readdatavalid,
   output logic                err_unexpected_rdv
);
   localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;

   sram_cmd_t         cmd_q, cmd_d;
   sram_cmd_t         port_cmd [2];
   logic [1:0]        req, is_wr, elig, grant;
   logic              rd_slot;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   port_id_t          head_tag, push_tag;
   logic [CNT_W-1:0]  unused_fifo_count;
   logic [1:0]        rdv_q, rdv_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];
   logic              err_q, err_d;
`ifdef SRAM_ARB_RR_EN
   port_id_t          last_q, last_d;
`endif

   // A write beats a simultaneous read on the same port.
   always_comb begin
      port_cmd[0] = '{addr: m0.address, be: m0.byteenable, rd: m0.read & ~m0.write,
                      wr: m0.write, wdata: m0.writedata};
      port_cmd[1] = '{addr: m1.address, be: m1.byteenable, rd: m1.read & ~m1.write,
                      wr: m1.write, wdata: m1.writedata};
   end

   // A return popping this cycle frees its slot for a read accepted in the same cycle.
   always_comb begin
      fifo_pop = controller_readdatavalid & ~fifo_empty;
      rd_slot  = ~fifo_full | fifo_pop;
      req      = {m1.read | m1.write, m0.read | m0.write};
      is_wr    = {m1.write, m0.write};
      elig     = req & (is_wr | {2{rd_slot}});
`ifdef SRAM_ARB_RR_EN
      grant    = (&elig) ? (last_q[0] ? 2'b01 : 2'b10) : elig;
`else
      grant    = elig[1] ? 2'b10 : elig;
`endif
      fifo_push = |(grant & ~is_wr);
      push_tag  = port_id_t'(grant[1]);
   end

`ifdef SRAM_ARB_RR_EN
   always_comb begin
      last_d = last_q;
      if (|grant) last_d = port_id_t'(grant[1]);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) last_q <= port_id_t'(1);
      else                last_q <= last_d;
   end
`endif

   always_comb begin
      cmd_d    = cmd_q;
      cmd_d.rd = 1'b0;
      cmd_d.wr = 1'b0;
      if (grant[1])      cmd_d = port_cmd[1];
      else if (grant[0]) cmd_d = port_cmd[0];
      rdv_d   = '0;
      rdata_d = rdata_q;
      err_d   = err_q | (controller_readdatavalid & fifo_empty);
      if (fifo_pop) begin
         rdv_d[head_tag]   = 1'b1;
         rdata_d[head_tag] = controller_readdata;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cmd_q   <= '0;
         rdv_q   <= '0;
         rdata_q <= '{default: '0};
         err_q   <= 1'b0;
      end else begin
         cmd_q   <= cmd_d;
         rdv_q   <= rdv_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   sram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .push_tag (push_tag),
      .head_tag (head_tag),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (unused_fifo_count)
   );

   assign m0.waitrequest   = ~grant[0];
   assign m1.waitrequest   = ~grant[1];
   assign m0.readdatavalid = rdv_q[0];
   assign m1.readdatavalid = rdv_q[1];
   assign m0.readdata      = rdata_q[0];
   assign m1.readdata      = rdata_q[1];

   assign controller_address    = cmd_q.addr;
   assign controller_byteenable = cmd_q.be;
   assign controller_read       = cmd_q.rd;
   assign controller_write      = cmd_q.wr;
   assign controller_writedata  = cmd_q.wdata;
   assign err_unexpected_rdv    = err_q;
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller Avalon-MM slave port between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Sits between the core's memory ports and the SRAM controller.
- Issues at most one command per cycle.
- Tracks outstanding reads in an in-order tag FIFO and steers each returned readdatavalid/readdata to the port that issued the read.

Parameters:
- ADDR_W, 20, word address width.
- DATA_W, 16, data width.
- BE_W, 2, byteenable width (DATA_W/8).
- MAX_PENDING, 4, maximum outstanding reads; power of two, at least 2.

Ports:
- clk_clk  input  1  clock.
- reset_reset_n  input  1  asynchronous active-low reset.
- m{0,1}_address  input  ADDR_W  requester address.
- m{0,1}_byteenable  input  BE_W  requester byte enables.
- m{0,1}_read  input  1  read request; held until accepted.
- m{0,1}_write  input  1  write request; held until accepted.
- m{0,1}_writedata  input  DATA_W  write data.
- m{0,1}_waitrequest  output  1  low in the cycle the request is accepted.
- m{0,1}_readdata  output  DATA_W  returned read data.
- m{0,1}_readdatavalid  output  1  one-cycle strobe for this port's read return.
- controller_address  output  ADDR_W  to SRAM controller.
- controller_byteenable  output  BE_W  to SRAM controller.
- controller_read  output  1  to SRAM controller.
- controller_write  output  1  to SRAM controller.
- controller_writedata  output  DATA_W  to SRAM controller.
- controller_readdata  input  DATA_W  from SRAM controller.
- controller_readdatavalid  input  1  from SRAM controller.
- err_unexpected_rdv  output  1  sticky; readdatavalid seen with no read pending.

Behaviour:
- Reset, asynchronous: all controller_* outputs 0; both readdatavalid 0; both readdata 0; err_unexpected_rdv 0; tag FIFO emptied; round-robin pointer set to port 1.
- Request: port p is requesting when m_p_read or m_p_write is high. Read and write both high is illegal; write takes precedence.
- Eligibility: a read is eligible only when pending < MAX_PENDING. A write is always eligible.
- Selection: among eligible requesters. Fixed priority (default): port 1 wins over port 0.
- Waitrequest: the winner's waitrequest is low combinationally in the accept cycle N. A non-winner or ineligible requester sees waitrequest high. An idle port sees waitrequest high.
- Command timing: the accepted command is registered and presented on controller_* in cycle N+1 for exactly one cycle. When nothing is accepted, controller_read and controller_write are 0; address and data hold their last values.
- Read tagging: on a read accept, port id p is pushed into the tag FIFO.
- Read return: on controller_readdatavalid, the FIFO head tag t is popped.
  - m_t_readdatavalid is asserted one cycle later, registered, with m_t_readdata equal to controller_readdata.
  - The other port's readdatavalid stays 0.
- Push and pop in the same cycle are allowed: count unchanged, including at count = MAX_PENDING.
- Full FIFO: reads stall via waitrequest high; writes from either port still proceed (controller is in-order).
- Empty FIFO with controller_readdatavalid: no port strobed, err_unexpected_rdv set until reset.
- Reset mid-operation: in-flight returns are lost. Returns arriving after reset with an empty FIFO raise err_unexpected_rdv; software clears the error by reset only.
- Pointers wrap modulo MAX_PENDING; count width is clog2(MAX_PENDING)+1.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin. The port not granted most recently has priority when both are eligible; the pointer updates only on an accept.
- Undefined: fixed priority, port 1 over port 0; port 0 may starve under continuous port 1 traffic.

Decomposition:
- Package sram_arb_pkg holds:
  - ADDR_W, DATA_W, BE_W constants;
  - typedef port_id_t (1 bit);
  - typedef sram_cmd_t struct: addr, be, rd, wr, wdata.
- One sub-module, sram_arb_tag_fifo: MAX_PENDING x 1-bit in-order FIFO with push, pop, full, empty and count.

Test Plan:
- Port 0 reads 0x00010 alone → waitrequest low in cycle N; controller_read=1 with address 0x00010 in N+1. Controller returns 0xBEEF two cycles later → m0_readdatavalid pulses with 0xBEEF; m1_readdatavalid stays 0.
- Both ports request in the same cycle, port 0 write 0x00020/0x1234, port 1 read 0x00030, default build → port 1 accepted first, port 0 in the next cycle; controller sees the read then the write, back-to-back.
- Port 1 issues 4 reads without returns, MAX_PENDING=4 → fifth read held with waitrequest high. A simultaneous port 0 write is accepted. The first return frees the slot and the stalled read is accepted in that same cycle.
- Interleaved reads tagged 0,1,1,0 with returns 0xA, 0xB, 0xC, 0xD → m0 gets 0xA and 0xD, m1 gets 0xB and 0xC, in order.
- controller_readdatavalid pulsed with the FIFO empty → no port strobe; err_unexpected_rdv=1 and it stays high until reset_reset_n goes low.
- SRAM_ARB_RR_EN defined, both ports requesting continuously for 6 cycles → grants alternate 0,1,0,1,0,1, starting with port 0 after reset.
